rr_stream_mux: RTL

Parametrised N-channel stream multiplexer with valid/ready handshakes on every input and on the output. It selects one input per transfer, either by an explicit select (fixed mode, the legacy 4:1 mux behaviour) or by round-robin arbitration, and registers the result in a single output stage. It sits between several producer streams and one shared consumer, replacing hard-wired 4:1 muxes in the datapath.

---
 rtl/mux_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/rr_stream_mux.sv | 100 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package mux_pkg;

    localparam int unsigned MAX_SEL_W = 4;

    typedef logic [MAX_SEL_W-1:0] ch_id_t;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester after ptr, wrapping back to ptr last.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    int unsigned sum;
    ch_id_t      cand;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = 0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            // Offset search from ptr+1; the ptr channel itself is reached last.
            sum = int'(unsigned'(ptr)) + off;
            if (sum >= NUM_CH) sum = sum - NUM_CH;
            cand = ch_id_t'(sum);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (en && !gnt_vld && cand == ch_id_t'(i) && req[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration
// feeding a single registered output stage.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     rr_en,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    mode_e             mode;
    logic              load_en, fix_vld, arb_vld, gnt_vld, xfer;
    logic [SEL_W-1:0]  arb_idx, gnt;
    logic [DATA_W-1:0] gnt_data;

    assign mode = mode_e'(rr_en);

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (mode == MODE_RR),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        // Gating with rst_n keeps in_ready low while reset is held.
        load_en = rst_n && (!out_valid_q || out_ready);

        fix_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) fix_vld = 1'b1;
        end

        gnt     = (mode == MODE_RR) ? arb_idx : sel;
        gnt_vld = (mode == MODE_RR) ? arb_vld : fix_vld;
        xfer    = load_en && gnt_vld;

        in_ready = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                gnt_data    = in_data[i*DATA_W +: DATA_W];
                in_ready[i] = xfer;
            end
        end

        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_ch_d    = gnt;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) ptr_d = gnt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SEL_W'(NUM_CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
